// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus-master DMA: FSM states, control-bus bit
// positions and the strobe pattern helper.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE,
    S_GAP,
    S_FINISH
  } state_t;

  // ctrl_bus = {mreq_n, iorq_n, rd_n, wr_n}
  localparam int CTRL_MREQ = 3;
  localparam int CTRL_IORQ = 2;
  localparam int CTRL_RD   = 1;
  localparam int CTRL_WR   = 0;

  localparam logic [3:0] CTRL_IDLE = 4'hF;

  // Active strobe pattern: exactly one of mreq_n/iorq_n and one of rd_n/wr_n low.
  function automatic logic [3:0] ctrl_strobe(input logic io, input logic wr);
    logic [3:0] c;
    c = CTRL_IDLE;
    if (io) c[CTRL_IORQ] = 1'b0;
    else    c[CTRL_MREQ] = 1'b0;
    if (wr) c[CTRL_WR] = 1'b0;
    else    c[CTRL_RD] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO for the DMA read path. A push lands in the
// array and becomes visible one cycle later; pop while full may accept a push.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/z80_bus_dma.sv
// Z80 bus-master DMA engine: acquires the bus via BUSREQ/BUSACK and moves
// words between the host stream ports and Z80 memory or a fixed I/O port.
module z80_bus_dma #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 17,
  parameter int BURST_LEN   = 256,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int REL_GAP     = 8,
  parameter int ACK_TIMEOUT = 4095,
  parameter int RD_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_io,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic [3:0]        ctrl_bus
);
  import z80_bus_pkg::*;

  localparam int CNT_W = 16;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_ack_meta;
  logic              r_ack_sync;
  logic              r_write;
  logic              r_io;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_burst;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_have;
  logic              r_oe;
  logic [DATA_W-1:0] r_data_out;
  logic              r_done;
  logic              r_error;

  logic w_ack_low;
  logic w_req_tmo;
  logic w_setup_go;
  logic w_setup_end;
  logic w_strobe_end;
  logic w_burst_end;
  logic w_gap_end;
  logic w_wr_take;
  logic w_fifo_push;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_owned;

  assign w_ack_low    = !r_ack_sync;
  assign w_req_tmo    = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_setup_go   = r_write ? wr_valid : !w_fifo_full;
  assign w_setup_end  = (r_cnt == CNT_W'(SETUP_CYC - 1));
  assign w_strobe_end = (r_cnt == CNT_W'(STROBE_CYC - 1));
  assign w_burst_end  = (BURST_LEN != 0) && (r_burst == LEN_W'(BURST_LEN - 1));
  assign w_gap_end    = (REL_GAP <= 1) || (r_cnt == CNT_W'(REL_GAP - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack_meta <= 1'b1;
      r_ack_sync <= 1'b1;
    end else begin
      r_ack_meta <= bus_ack_n;
      r_ack_sync <= r_ack_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_wr_take    = 1'b0;
    w_fifo_push  = 1'b0;
    w_owned      = 1'b0;
    bus_req_n    = 1'b1;
    ctrl_bus     = CTRL_IDLE;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_state_next = (cmd_len == '0) ? S_IDLE : S_REQ;
      end
      S_REQ: begin
        bus_req_n = 1'b0;
        if (w_ack_low)      w_state_next = S_SETUP;
        else if (w_req_tmo) w_state_next = S_IDLE;
      end
      S_SETUP: begin
        bus_req_n = 1'b0;
        w_owned   = 1'b1;
        if (!r_have)          w_wr_take    = r_write && wr_valid;
        else if (w_setup_end) w_state_next = S_STROBE;
      end
      S_STROBE: begin
        bus_req_n = 1'b0;
        w_owned   = 1'b1;
        // Never strobe a bus we do not currently hold.
        if (w_ack_low) ctrl_bus = ctrl_strobe(r_io, r_write);
        if (w_strobe_end) begin
          w_state_next = S_HOLD;
          w_fifo_push  = !r_write;
        end
      end
      S_HOLD: begin
        bus_req_n = 1'b0;
        w_owned   = 1'b1;
        if (r_rem == LEN_W'(1)) w_state_next = S_FINISH;
        else if (w_burst_end)   w_state_next = S_RELEASE;
        else                    w_state_next = S_SETUP;
      end
      S_RELEASE: if (!w_ack_low) w_state_next = S_GAP;
      S_GAP:     if (w_gap_end)  w_state_next = S_REQ;
      S_FINISH:  if (!w_ack_low) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_io       <= 1'b0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_burst    <= '0;
      r_cnt      <= '0;
      r_have     <= 1'b0;
      r_oe       <= 1'b0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_write <= cmd_write;
            r_io    <= cmd_io;
            r_addr  <= cmd_addr;
            r_rem   <= cmd_len;
            r_cnt   <= '0;
            if (cmd_len == '0) r_done <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_ack_low) begin
            r_cnt   <= '0;
            r_burst <= '0;
          end else if (w_req_tmo) begin
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETUP: begin
          // First wait for a word (write) or a free FIFO slot (read), then time the setup.
          if (!r_have) begin
            if (w_setup_go) begin
              r_have <= 1'b1;
              r_cnt  <= '0;
              if (r_write) begin
                r_data_out <= wr_data;
                r_oe       <= 1'b1;
              end
            end
          end else if (w_setup_end) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (w_strobe_end) r_cnt <= '0;
          else              r_cnt <= r_cnt + CNT_W'(1);
        end
        S_HOLD: begin
          r_oe    <= 1'b0;
          r_have  <= 1'b0;
          r_cnt   <= '0;
          r_rem   <= r_rem - LEN_W'(1);
          r_burst <= r_burst + LEN_W'(1);
          if (!r_io) r_addr <= r_addr + ADDR_W'(1);
        end
        S_RELEASE: r_cnt <= '0;
        S_GAP: begin
          if (w_gap_end) r_cnt <= '0;
          else           r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FINISH: if (!w_ack_low) r_done <= 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_fifo_push),
    .i_data  (data_in),
    .i_pop   (rd_ready),
    .o_data  (rd_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wr_ready  = w_wr_take;
  assign rd_valid  = !w_fifo_empty;
  assign done      = r_done;
  assign error     = r_error;
  assign addr      = w_owned ? r_addr : '0;
  assign data_out  = r_data_out;
  assign data_oe   = r_oe;

endmodule

// File: tb/tb_z80_bus_dma.sv
// Directed bench for z80_bus_dma with a simple Z80 bus model (delayed BUSACK,
// address-decoded memory, incrementing I/O port) and per-scenario checks.
module tb_z80_bus_dma;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int LEN_W       = 17;
  localparam int BURST_LEN   = 2;
  localparam int SETUP_CYC   = 1;
  localparam int STROBE_CYC  = 3;
  localparam int REL_GAP     = 8;
  localparam int ACK_TIMEOUT = 40;
  localparam int RD_DEPTH    = 4;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_io;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic              bus_req_n;
  logic              bus_ack_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic [3:0]        ctrl_bus;

  z80_bus_dma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN),
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .REL_GAP(REL_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT), .RD_DEPTH(RD_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_io(cmd_io), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .error(error),
    .bus_req_n(bus_req_n), .bus_ack_n(bus_ack_n), .addr(addr),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .ctrl_bus(ctrl_bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus model: BUSACK follows BUSREQ two cycles later unless stuck high.
  logic       stuck;
  logic [1:0] ack_pipe = 2'b11;
  always @(posedge clk) ack_pipe <= {ack_pipe[0], bus_req_n};
  assign bus_ack_n = stuck | ack_pipe[1];

  logic [7:0] io_cnt   = 8'h00;
  logic [7:0] io_start = 8'h00;
  always_comb begin
    data_in = 8'h00;
    if (!ctrl_bus[2]) data_in = 8'h50 + (io_cnt - io_start);
    else begin
      case (addr)
        16'hFFFE: data_in = 8'hA1;
        16'hFFFF: data_in = 8'hB2;
        16'h0000: data_in = 8'hC3;
        default:  data_in = 8'h00;
      endcase
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [3:0]  prev_ctrl   = 4'hF;
  logic        prev_req    = 1'b1;
  int          ev_count    = 0;
  int          done_cnt    = 0;
  int          err_cnt     = 0;
  int          viol        = 0;
  int          req_low_cnt = 0;
  int          hi_run      = 0;
  logic [15:0] ev_addr[$];
  logic [7:0]  ev_data[$];
  logic [3:0]  ev_ctrl[$];
  int          ev_len[$];
  int          rise_ev[$];
  int          gap_q[$];
  logic [7:0]  rd_q[$];

  initial forever begin
    @(negedge clk);
    if (ctrl_bus != 4'hF) begin
      if (prev_ctrl == 4'hF) begin
        ev_addr.push_back(addr);
        ev_data.push_back(data_out);
        ev_ctrl.push_back(ctrl_bus);
        ev_len.push_back(1);
      end else begin
        ev_len[ev_len.size()-1] = ev_len[ev_len.size()-1] + 1;
      end
      if (bus_ack_n) viol++;
      if (!ctrl_bus[3] && !ctrl_bus[2]) viol++;
      if (!ctrl_bus[0] && !data_oe) viol++;
    end else if (prev_ctrl != 4'hF) begin
      ev_count++;
      if (!prev_ctrl[2]) io_cnt = io_cnt + 8'd1;
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (!bus_req_n) req_low_cnt++;
    if (bus_req_n && !prev_req) begin
      rise_ev.push_back(ev_count);
      hi_run = 0;
    end
    if (bus_req_n) hi_run++;
    if (!bus_req_n && prev_req) gap_q.push_back(hi_run);
    prev_ctrl = ctrl_bus;
    prev_req  = bus_req_n;
  end

  initial forever begin
    @(posedge clk);
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
  end

  // Write-stream source: presents wr_tbl entries while wr_sent < wr_limit.
  logic [7:0] wr_tbl [16];
  int         wr_sent  = 0;
  int         wr_limit = 0;
  initial begin
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(posedge clk);
      if (wr_valid && wr_ready) wr_sent++;
      #1;
      wr_valid = (wr_sent < wr_limit);
      wr_data  = wr_tbl[wr_sent[3:0]];
    end
  end

  task automatic issue(input logic wr, input logic io, input logic [15:0] a, input logic [16:0] len);
    cmd_write = wr;
    cmd_io    = io;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    $display("[TB] cmd write=%0b io=%0b addr=%h len=%0d", wr, io, a, len);
  endtask

  task automatic wait_idle(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic load_wr(input logic [7:0] base, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = wr_limit + i;
      wr_tbl[idx[3:0]] = base + 8'(i);
    end
    wr_limit = wr_limit + n;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_io = 1'b0;
    cmd_addr = '0; cmd_len = '0; rd_ready = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_req_n, ctrl_bus, data_oe, busy, done, error, wr_ready, rd_valid, cmd_ready} !== 12'b1_1111_000000_1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got req=%b ctrl=%h oe=%b busy=%b done=%b err=%b wrr=%b rdv=%b rdy=%b expected 1 F 0 0 0 0 0 0 1",
               bus_req_n, ctrl_bus, data_oe, busy, done, error, wr_ready, rd_valid, cmd_ready);
    end
    tests_run++;
    if (addr !== 16'h0000 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h data=%h expected 0000 00", addr, data_out);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_mem_write();
    int e0, d0;
    logic ok;
    e0 = ev_addr.size();
    d0 = done_cnt;
    load_wr(8'h11, 4);
    for (int i = 0; i < 4; i++) wr_tbl[(wr_limit - 4 + i) % 16] = 8'h11 * 8'(i + 1);
    issue(1'b1, 1'b0, 16'h4000, 17'd4);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL memwr_timeout: got busy expected idle"); end
    tests_run++;
    if (ev_addr.size() - e0 !== 4) begin
      tests_failed++;
      $display("FAIL memwr_count: got %0d strobes expected 4", ev_addr.size() - e0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (ev_addr[e0+i] !== 16'h4000 + 16'(i) || ev_data[e0+i] !== 8'h11 * 8'(i + 1) ||
            ev_ctrl[e0+i] !== 4'b0110 || ev_len[e0+i] !== STROBE_CYC) begin
          tests_failed++;
          $display("FAIL memwr_word%0d: got addr=%h data=%h ctrl=%b len=%0d expected %h %h 0110 %0d", i,
                   ev_addr[e0+i], ev_data[e0+i], ev_ctrl[e0+i], ev_len[e0+i],
                   16'h4000 + 16'(i), 8'h11 * 8'(i + 1), STROBE_CYC);
        end
      end
    end
    tests_run++;
    if (done_cnt - d0 !== 1 || wr_sent !== wr_limit || viol !== 0) begin
      tests_failed++;
      $display("FAIL memwr_done: got done=%0d left=%0d viol=%0d expected 1 0 0", done_cnt - d0, wr_limit - wr_sent, viol);
    end
  endtask

  task automatic test_mem_read_wrap();
    int e0, r0, d0;
    logic ok;
    logic [15:0] exp_a [3];
    logic [7:0]  exp_d [3];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    exp_d = '{8'hA1, 8'hB2, 8'hC3};
    e0 = ev_addr.size(); r0 = rd_q.size(); d0 = done_cnt;
    rd_ready = 1'b1;
    issue(1'b0, 1'b0, 16'hFFFE, 17'd3);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || ev_addr.size() - e0 !== 3 || rd_q.size() - r0 !== 3) begin
      tests_failed++;
      $display("FAIL memrd_count: got idle=%b strobes=%0d pops=%0d expected 1 3 3", ok, ev_addr.size() - e0, rd_q.size() - r0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (ev_addr[e0+i] !== exp_a[i] || ev_ctrl[e0+i] !== 4'b0101 || rd_q[r0+i] !== exp_d[i]) begin
          tests_failed++;
          $display("FAIL memrd_word%0d: got addr=%h ctrl=%b rd=%h expected %h 0101 %h", i,
                   ev_addr[e0+i], ev_ctrl[e0+i], rd_q[r0+i], exp_a[i], exp_d[i]);
        end
      end
    end
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL memrd_done: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_burst();
    int c0, r0, g0;
    logic ok;
    c0 = ev_count; r0 = rise_ev.size(); g0 = gap_q.size();
    load_wr(8'h01, 5);
    issue(1'b1, 1'b0, 16'h8000, 17'd5);
    wait_idle(3000, ok);
    tests_run++;
    if (!ok || rise_ev.size() - r0 !== 3 || gap_q.size() - g0 !== 3) begin
      tests_failed++;
      $display("FAIL burst_tenures: got idle=%b rises=%0d falls=%0d expected 1 3 3", ok, rise_ev.size() - r0, gap_q.size() - g0);
    end else begin
      tests_run++;
      if (rise_ev[r0] - c0 !== 2 || rise_ev[r0+1] - c0 !== 4 || rise_ev[r0+2] - c0 !== 5) begin
        tests_failed++;
        $display("FAIL burst_release_pts: got %0d,%0d,%0d expected 2,4,5",
                 rise_ev[r0] - c0, rise_ev[r0+1] - c0, rise_ev[r0+2] - c0);
      end
      tests_run++;
      if (gap_q[g0+1] < REL_GAP || gap_q[g0+2] < REL_GAP) begin
        tests_failed++;
        $display("FAIL burst_gap: got %0d,%0d expected >= %0d", gap_q[g0+1], gap_q[g0+2], REL_GAP);
      end
    end
  endtask

  task automatic test_io_read_stall();
    int e0, r0;
    logic ok;
    e0 = ev_addr.size(); r0 = rd_q.size();
    io_start = io_cnt;
    rd_ready = 1'b0;
    issue(1'b0, 1'b1, 16'h00FE, 17'd6);
    repeat (300) @(negedge clk);
    tests_run++;
    if (ev_addr.size() - e0 !== RD_DEPTH || !rd_valid || !busy || rd_q.size() !== r0) begin
      tests_failed++;
      $display("FAIL io_stall: got strobes=%0d rdv=%b busy=%b expected %0d 1 1", ev_addr.size() - e0, rd_valid, busy, RD_DEPTH);
    end
    rd_ready = 1'b1;
    wait_idle(3000, ok);
    tests_run++;
    if (!ok || ev_addr.size() - e0 !== 6 || rd_q.size() - r0 !== 6) begin
      tests_failed++;
      $display("FAIL io_drain: got idle=%b strobes=%0d pops=%0d expected 1 6 6", ok, ev_addr.size() - e0, rd_q.size() - r0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (ev_addr[e0+i] !== 16'h00FE || ev_ctrl[e0+i] !== 4'b1001 || rd_q[r0+i] !== 8'h50 + 8'(i)) begin
          tests_failed++;
          $display("FAIL io_word%0d: got addr=%h ctrl=%b rd=%h expected 00FE 1001 %h", i,
                   ev_addr[e0+i], ev_ctrl[e0+i], rd_q[r0+i], 8'h50 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_ack_timeout();
    int c0, e0, d0, n;
    c0 = ev_count; e0 = err_cnt; d0 = done_cnt; n = 0;
    stuck = 1'b1;
    issue(1'b0, 1'b0, 16'h1234, 17'd2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (error) break;
    end
    tests_run++;
    if (n < ACK_TIMEOUT || n > ACK_TIMEOUT + 2) begin
      tests_failed++;
      $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d", n, ACK_TIMEOUT, ACK_TIMEOUT + 2);
    end
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 1 || !bus_req_n || busy || ev_count !== c0 || done_cnt !== d0) begin
      tests_failed++;
      $display("FAIL tmo_state: got err=%0d req=%b busy=%b strobes=%0d done=%0d expected 1 1 0 0 0",
               err_cnt - e0, bus_req_n, busy, ev_count - c0, done_cnt - d0);
    end
    stuck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe();
    int q0, d0, n;
    n = 0;
    load_wr(8'hAA, 2);
    issue(1'b1, 1'b0, 16'h2000, 17'd2);
    while (ctrl_bus == 4'hF && n < 200) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (n >= 200 || ctrl_bus !== 4'hF || !bus_req_n || data_oe || busy || addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_async: got wait=%0d ctrl=%h req=%b oe=%b busy=%b addr=%h expected <200 F 1 0 0 0000",
               n, ctrl_bus, bus_req_n, data_oe, busy, addr);
    end
    wr_limit = wr_sent;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    q0 = req_low_cnt; d0 = done_cnt;
    issue(1'b1, 1'b0, 16'h5555, 17'd0);
    @(negedge clk);
    tests_run++;
    if (!done || busy) begin
      tests_failed++;
      $display("FAIL zero_len_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done) begin
      tests_failed++;
      $display("FAIL zero_len_pulse: got done=%b expected 0", done);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (req_low_cnt !== q0 || done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL zero_len_noreq: got req_low=%0d done=%0d expected 0 1", req_low_cnt - q0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_read_wrap();
    test_burst();
    test_io_read_stall();
    test_ack_timeout();
    test_reset_mid_strobe();
    tests_run++;
    if (viol !== 0) begin
      tests_failed++;
      $display("FAIL bus_rules: got %0d violations expected 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
